// File: rtl/clp_pkg.sv
// Shared definitions for the CLP layer sequencer: FSM states, instruction
// field positions, legal kernel sizes and the line-buffer fill length.
package clp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FILL,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } clp_state_e;

    localparam int TYPE_LSB   = 0;
    localparam int TYPE_W     = 4;
    localparam int KERN_LSB   = 4;
    localparam int KERN_W     = 3;
    localparam int OUTA_LSB   = 20;
    localparam int OUTA_W     = 10;
    localparam int SCAL_LSB   = 30;
    localparam int SCAL_W     = 4;
    localparam int WGT_LSB    = 50;
    localparam int WGT_W      = 10;
    localparam int FAMT_LSB   = 60;
    localparam int FAMT_W     = 10;
    localparam int FADDR_LSB  = 70;
    localparam int FADDR_W    = 15;
    localparam int MAPW_LSB   = 85;
    localparam int INSTR_TOP  = 99;

    localparam logic [KERN_W-1:0] KERNEL_1 = 3'd1;
    localparam logic [KERN_W-1:0] KERNEL_3 = 3'd3;
    localparam logic [KERN_W-1:0] KERNEL_5 = 3'd5;

    function automatic logic is_legal_kernel(input logic [KERN_W-1:0] k);
        return (k == KERNEL_1) || (k == KERNEL_3) || (k == KERNEL_5);
    endfunction

    // Line-buffer preload length: a 1x1 kernel needs no rows buffered ahead.
    function automatic logic [3:0] fill_cycles(input logic [KERN_W-1:0] k);
        return (k == KERNEL_1) ? 4'd1 : ({1'b0, k} + 4'd2);
    endfunction

endpackage

// File: rtl/clp_map_counter.sv
// Column/row position counters over the output map, with the terminal flag
// and the registered compute-enable window.
module clp_map_counter #(
    parameter int COL_W = 8,
    parameter int ROW_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             active,
    input  logic             active_next,
    input  logic [COL_W-1:0] map_w,
    input  logic [COL_W-1:0] win_lim,
    input  logic [ROW_W-1:0] last_row,
    output logic [COL_W-1:0] col_q,
    output logic [ROW_W-1:0] row_q,
    output logic             terminal,
    output logic             enable_q
);

    logic [COL_W-1:0] col_d;
    logic [ROW_W-1:0] row_d;
    logic             enable_d;
    logic             col_wrap;

    assign col_wrap = (col_q == (map_w - COL_W'(1)));
    assign terminal = active && col_wrap && (row_q == last_row);

    // Counters sit at zero outside the run so the first run cycle is (0,0).
    always_comb begin
        col_d = '0;
        row_d = '0;
        if (active && active_next) begin
            if (col_wrap) begin
                col_d = '0;
                row_d = row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
                row_d = row_q;
            end
        end
        enable_d = active_next && (col_d <= win_lim);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q    <= '0;
            row_q    <= '0;
            enable_q <= 1'b0;
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            enable_q <= enable_d;
        end
    end

endmodule

// File: rtl/clp_layer_sequencer.sv
// Per-layer CLP sequencer: latches a layer instruction on start, validates it,
// then walks fill, run and drain phases with a start/busy/done handshake.
module clp_layer_sequencer
    import clp_pkg::*;
#(
    parameter int INSTR_WIDTH = 100,
    parameter int COL_W       = 8,
    parameter int ROW_W       = 7,
    parameter int PIPE_LAT    = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [INSTR_WIDTH-1:0] instruction,
    output logic                   busy,
    output logic                   done,
    output logic                   instr_err,
    output logic [3:0]             clp_type,
    output logic [2:0]             clp_kernel,
    output logic [14:0]            feat_addr,
    output logic [9:0]             feat_amount,
    output logic [9:0]             weight_addr,
    output logic [3:0]             scaler_addr,
    output logic [9:0]             out_addr,
    output logic                   clp_enable,
    output logic                   clp_addr_clear,
    output logic [ROW_W-1:0]       row_idx,
    output logic [COL_W-1:0]       col_idx
);

    localparam int MAPH_LSB = INSTR_TOP - ROW_W + 1;
    localparam int DRAIN_W  = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    clp_state_e state_q, state_d;

    logic [3:0]         type_q,  type_d;
    logic [2:0]         kern_q,  kern_d;
    logic [14:0]        faddr_q, faddr_d;
    logic [9:0]         famt_q,  famt_d;
    logic [9:0]         wgt_q,   wgt_d;
    logic [3:0]         scal_q,  scal_d;
    logic [9:0]         outa_q,  outa_d;
    logic [COL_W-1:0]   mapw_q,  mapw_d;
    logic [ROW_W-1:0]   maph_q,  maph_d;
    logic [COL_W-1:0]   win_lim_q,  win_lim_d;
    logic [ROW_W-1:0]   last_row_q, last_row_d;
    logic [2:0]         fill_q,  fill_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;
    logic               err_q,   err_d;
    logic               aclr_q,  aclr_d;
    logic               load_bad;
    logic               terminal;
    logic               unused_bits;

    assign unused_bits = ^{instruction[19:7], instruction[49:34]};

    // Width/height checks use the kernel zero-extended to each counter width.
    assign load_bad = !is_legal_kernel(kern_q)
                   || (mapw_q < COL_W'(kern_q))
                   || (maph_q < ROW_W'(kern_q));

    always_comb begin
        state_d    = state_q;
        type_d     = type_q;
        kern_d     = kern_q;
        faddr_d    = faddr_q;
        famt_d     = famt_q;
        wgt_d      = wgt_q;
        scal_d     = scal_q;
        outa_d     = outa_q;
        mapw_d     = mapw_q;
        maph_d     = maph_q;
        win_lim_d  = win_lim_q;
        last_row_d = last_row_q;
        fill_d     = fill_q;
        drain_d    = drain_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d = ST_LOAD;
                    type_d  = instruction[TYPE_LSB +: TYPE_W];
                    kern_d  = instruction[KERN_LSB +: KERN_W];
                    faddr_d = instruction[FADDR_LSB +: FADDR_W];
                    famt_d  = instruction[FAMT_LSB +: FAMT_W];
                    wgt_d   = instruction[WGT_LSB +: WGT_W];
                    scal_d  = instruction[SCAL_LSB +: SCAL_W];
                    outa_d  = instruction[OUTA_LSB +: OUTA_W];
                    mapw_d  = instruction[MAPW_LSB +: COL_W];
                    maph_d  = instruction[MAPH_LSB +: ROW_W];
                end
            end
            ST_LOAD: begin
                if (load_bad) begin
                    state_d = ST_DONE;
                end else begin
                    state_d    = ST_FILL;
                    fill_d     = 3'(fill_cycles(kern_q) - 4'd1);
                    win_lim_d  = mapw_q - COL_W'(kern_q);
                    last_row_d = maph_q - ROW_W'(kern_q);
                end
            end
            ST_FILL: begin
                if (fill_q == 3'd0) state_d = ST_RUN;
                else                fill_d  = fill_q - 3'd1;
            end
            ST_RUN: begin
                if (terminal) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_W'(PIPE_LAT - 1);
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) state_d = ST_DONE;
                else               drain_d = drain_q - DRAIN_W'(1);
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (abort) state_d = ST_IDLE;

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
        err_d  = (state_d == ST_DONE) && (state_q == ST_LOAD);
        aclr_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            type_q     <= '0;
            kern_q     <= '0;
            faddr_q    <= '0;
            famt_q     <= '0;
            wgt_q      <= '0;
            scal_q     <= '0;
            outa_q     <= '0;
            mapw_q     <= '0;
            maph_q     <= '0;
            win_lim_q  <= '0;
            last_row_q <= '0;
            fill_q     <= '0;
            drain_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            aclr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            kern_q     <= kern_d;
            faddr_q    <= faddr_d;
            famt_q     <= famt_d;
            wgt_q      <= wgt_d;
            scal_q     <= scal_d;
            outa_q     <= outa_d;
            mapw_q     <= mapw_d;
            maph_q     <= maph_d;
            win_lim_q  <= win_lim_d;
            last_row_q <= last_row_d;
            fill_q     <= fill_d;
            drain_q    <= drain_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            aclr_q     <= aclr_d;
        end
    end

    clp_map_counter #(
        .COL_W (COL_W),
        .ROW_W (ROW_W)
    ) u_map_counter (
        .clk         (clk),
        .rst_n       (rst_n),
        .active      (state_q == ST_RUN),
        .active_next (state_d == ST_RUN),
        .map_w       (mapw_q),
        .win_lim     (win_lim_q),
        .last_row    (last_row_q),
        .col_q       (col_idx),
        .row_q       (row_idx),
        .terminal    (terminal),
        .enable_q    (clp_enable)
    );

    assign busy           = busy_q;
    assign done           = done_q;
    assign instr_err      = err_q;
    assign clp_addr_clear = aclr_q;
    assign clp_type       = type_q;
    assign clp_kernel     = kern_q;
    assign feat_addr      = faddr_q;
    assign feat_amount    = famt_q;
    assign weight_addr    = wgt_q;
    assign scaler_addr    = scal_q;
    assign out_addr       = outa_q;

endmodule

// File: tb/tb_clp_layer_sequencer.sv
// Self-checking bench: every cycle of each layer is compared against the
// cycle-indexed timeline implied by the instruction's K, W and H.
module tb_clp_layer_sequencer;

    localparam int PIPE = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [99:0] instruction = '0;

    logic        busy, done, instr_err, clp_enable, clp_addr_clear;
    logic [3:0]  clp_type, scaler_addr;
    logic [2:0]  clp_kernel;
    logic [14:0] feat_addr;
    logic [9:0]  feat_amount, weight_addr, out_addr;
    logic [6:0]  row_idx;
    logic [7:0]  col_idx;

    int checks = 0;
    int failures = 0;

    clp_layer_sequencer #(
        .INSTR_WIDTH (100),
        .COL_W       (8),
        .ROW_W       (7),
        .PIPE_LAT    (PIPE)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .instruction    (instruction),
        .busy           (busy),
        .done           (done),
        .instr_err      (instr_err),
        .clp_type       (clp_type),
        .clp_kernel     (clp_kernel),
        .feat_addr      (feat_addr),
        .feat_amount    (feat_amount),
        .weight_addr    (weight_addr),
        .scaler_addr    (scaler_addr),
        .out_addr       (out_addr),
        .clp_enable     (clp_enable),
        .clp_addr_clear (clp_addr_clear),
        .row_idx        (row_idx),
        .col_idx        (col_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [99:0] mk(input int k, input int w, input int h);
        logic [99:0] v;
        v[31:0]  = $urandom;
        v[63:32] = $urandom;
        v[95:64] = $urandom;
        v[99:96] = 4'($urandom);
        v[6:4]   = 3'(k);
        v[92:85] = 8'(w);
        v[99:93] = 7'(h);
        return v;
    endfunction

    task automatic chk_fields(input string tag, input logic [99:0] ins);
        chk({tag, "_type"},  clp_type,    ins[3:0]);
        chk({tag, "_kern"},  clp_kernel,  ins[6:4]);
        chk({tag, "_outa"},  out_addr,    ins[29:20]);
        chk({tag, "_scal"},  scaler_addr, ins[33:30]);
        chk({tag, "_wgt"},   weight_addr, ins[59:50]);
        chk({tag, "_famt"},  feat_amount, ins[69:60]);
        chk({tag, "_faddr"}, feat_addr,   ins[84:70]);
    endtask

    // Launches ins in the current cycle (cycle 0) and checks every cycle up to
    // the IDLE cycle after done; optional abort and ignored mid-run start.
    task automatic run_instr(input string tag, input logic [99:0] ins,
                             input int abort_at, input int mid_at,
                             input logic [99:0] mid_ins);
        int k, w, h, f, r, run_start, run_end, done_at, t;
        bit legal, in_run, exp_en;
        k = int'(ins[6:4]);
        w = int'(ins[92:85]);
        h = int'(ins[99:93]);
        legal     = (k == 1 || k == 3 || k == 5) && (w >= k) && (h >= k);
        f         = (k == 1) ? 1 : k + 2;
        r         = h - k + 1;
        run_start = f + 2;
        run_end   = legal ? run_start + r * w : run_start;
        done_at   = legal ? run_end + PIPE : 2;
        $display("txn %s: K=%0d W=%0d H=%0d legal=%0d done_cycle=%0d abort_at=%0d",
                 tag, k, w, h, legal, done_at, abort_at);

        start = 1'b1;
        instruction = ins;
        step();
        start = 1'b0;
        instruction = mk(int'($urandom_range(0, 7)), 9, 9);

        for (int c = 1; c <= done_at + 1; c++) begin
            in_run = legal && (c >= run_start) && (c < run_end);
            t      = c - run_start;
            exp_en = in_run && ((t % w) <= (w - k));
            chk({tag, "_busy"},  busy,           (c <= done_at));
            chk({tag, "_done"},  done,           (c == done_at));
            chk({tag, "_err"},   instr_err,      (c == done_at) && !legal);
            chk({tag, "_en"},    clp_enable,     exp_en);
            chk({tag, "_aclr"},  clp_addr_clear, in_run);
            chk({tag, "_col"},   col_idx,        in_run ? (t % w) : 0);
            chk({tag, "_row"},   row_idx,        in_run ? (t / w) : 0);
            if (c == 1 || c == done_at || c == mid_at + 1)
                chk_fields(tag, ins);

            if (c == abort_at) begin
                abort = 1'b1;
                step();
                abort = 1'b0;
                chk({tag, "_abort_busy"}, busy,           0);
                chk({tag, "_abort_done"}, done,           0);
                chk({tag, "_abort_err"},  instr_err,      0);
                chk({tag, "_abort_en"},   clp_enable,     0);
                chk({tag, "_abort_aclr"}, clp_addr_clear, 0);
                chk({tag, "_abort_col"},  col_idx,        0);
                chk({tag, "_abort_row"},  row_idx,        0);
                return;
            end
            if (c == mid_at) begin
                start = 1'b1;
                instruction = mid_ins;
            end
            step();
            start = 1'b0;
        end
    endtask

    initial begin
        logic [99:0] ins;
        int k, w, h;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err",  instr_err, 0);
        chk("rst_en",   clp_enable, 0);
        chk("rst_aclr", clp_addr_clear, 0);
        chk("rst_row",  row_idx, 0);
        chk("rst_col",  col_idx, 0);
        chk_fields("rst", '0);
        rst_n = 1'b1;
        step();

        run_instr("k5", mk(5, 26, 30), -1, -1, '0);
        run_instr("k3", mk(3, 26, 30), -1, -1, '0);
        run_instr("k1", mk(1, 8, 4),   -1, -1, '0);
        run_instr("k4_err", mk(4, 26, 30), -1, -1, '0);
        run_instr("w3_err", mk(5, 3, 30),  -1, -1, '0);
        run_instr("h_err",  mk(3, 10, 2),  -1, -1, '0);

        run_instr("abort", mk(5, 26, 30), 100, -1, '0);
        step();
        run_instr("post_abort", mk(5, 26, 30), -1, -1, '0);

        run_instr("midstart", mk(3, 10, 8), -1, 30, mk(1, 5, 5));

        // Asynchronous reset in the middle of a run clears outputs at once.
        start = 1'b1;
        instruction = mk(3, 26, 30);
        step();
        start = 1'b0;
        repeat (60) step();
        rst_n = 1'b0;
        #1;
        $display("txn async_reset: rst_n asserted mid-run");
        chk("arst_busy", busy, 0);
        chk("arst_en",   clp_enable, 0);
        chk("arst_aclr", clp_addr_clear, 0);
        chk("arst_col",  col_idx, 0);
        chk("arst_row",  row_idx, 0);
        chk_fields("arst", '0);
        step();
        rst_n = 1'b1;
        step();
        chk("arst_idle_busy", busy, 0);

        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 2))
                    0:       k = 1;
                    1:       k = 3;
                    default: k = 5;
                endcase
            end else begin
                k = int'($urandom_range(0, 7));
            end
            w = int'($urandom_range(0, 20));
            h = int'($urandom_range(0, 12));
            ins = mk(k, w, h);
            run_instr($sformatf("rnd%0d", i), ins, -1, -1, '0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clp_layer_sequencer.md
# clp_layer_sequencer

Parametrised per-layer sequencer for the convolution layer processor (CLP). On a `start` pulse it latches one layer instruction, decodes the layer fields, and drives CLP `enable`/`addr_clear` over a configurable W×H feature map. It replaces fixed cycle counts with row/column counters derived from map size and kernel size. It adds a start/busy/done handshake, abort, illegal-instruction detection and a drain phase, and sits between the instruction fetch unit and the feature/weight/scaler memory controllers plus the CLP.

## Interface
- `INSTR_WIDTH`, 100, instruction word width (fields below fixed at bits 0..99)
- `COL_W`, 8, width of map-width field/column counter
- `ROW_W`, 7, width of map-height field/row counter
- `PIPE_LAT`, 4, CLP pipeline drain cycles after the last enabled column (≥1)
- `clk` in 1, clock
- `rst_n` in 1, reset, asynchronous, active-low
- `start` in 1, launch pulse; sampled only in IDLE
- `abort` in 1, synchronous cancel, any state
- `instruction` in INSTR_WIDTH, layer word; valid in the `start` cycle only
- `busy` out 1, high from the cycle after accepted `start` until the `done` cycle inclusive
- `done` out 1, one-cycle completion pulse
- `instr_err` out 1, valid with `done`; 1 = rejected instruction
- `clp_type` out 4, `clp_kernel` out 3, `feat_addr` out 15, `feat_amount` out 10, `weight_addr` out 10, `scaler_addr` out 4, `out_addr` out 10, latched fields
- `clp_enable` out 1, CLP compute enable
- `clp_addr_clear` out 1, CLP row-address advance/clear (high throughout RUN)
- `row_idx` out ROW_W, `col_idx` out COL_W, current output position

## Operation
- Instruction fields: [3:0] type, [6:4] kernel K, [29:20] out_addr, [33:30] scaler_addr, [59:50] weight_addr, [69:60] feat_amount, [84:70] feat_addr, [85+COL_W-1:85] W, [99:99-ROW_W+1] H.
- Fields latch only on an accepted `start` (IDLE and `start`=1). They hold until the next accepted start and do not change while busy.
- States: IDLE → LOAD → FILL → RUN → DRAIN → DONE → IDLE; LOAD → DONE on error.
- LOAD (1 cycle): K∉{1,3,5}, W<K or H<K → error path, `instr_err`=1, `clp_enable` never asserted.
- FILL: F cycles, F = 1 if K=1, else K+2 (line-buffer preload).
- RUN: R = H−K+1 output rows × W columns. `col_idx` counts 0..W−1 and wraps. `row_idx` increments on wrap. `clp_enable`=1 when `col_idx` ≤ W−K, else 0 (K−1 gap columns per row). RUN ends at `row_idx`=R−1, `col_idx`=W−1.
- DRAIN: PIPE_LAT cycles, `clp_enable`=0, `clp_addr_clear`=0.
- DONE: `done`=1 for 1 cycle, then IDLE.
- `start` while busy is ignored. `abort` takes priority over all transitions: IDLE next cycle, all control outputs 0, no `done`.
- `abort` and `start` in the same IDLE cycle: abort wins, start is dropped.
- Counter arithmetic is unsigned at COL_W/ROW_W. W−K and H−K are computed only after the LOAD check, so they never underflow.

## Timing
- Reset: state IDLE; all outputs and latched fields 0.
- All outputs are registered. With `start` sampled at cycle 0:
  - LOAD at cycle 1, `busy`=1 from cycle 1.
  - FILL at cycles 2..F+1.
  - First `clp_enable` at cycle F+2.
  - DRAIN starts at cycle F+2+R·W.
  - `done` at cycle F+2+R·W+PIPE_LAT.
- Error path: `done`=`instr_err`=1 at cycle 2.
- Back-to-back: a `start` sampled in the cycle after `done` is accepted (IDLE).

## Structure
- Shared package `clp_pkg`: state enum, instruction field bit positions, legal-kernel constants, the F(K) function.
- One sub-module `clp_map_counter` (column/row counters with wrap, terminal flag, enable window compare). The FSM and field latch stay in the top module.

## Test plan
- K=5, W=26, H=30, PIPE_LAT=4 → F=7, 26 rows of 22 enable-high/4 low, first enable cycle 9, `done` cycle 689, `instr_err`=0.
- K=3, W=26, H=30 → 28 rows, 24 high/2 low, first enable cycle 7, `done` cycle 739.
- K=1, W=8, H=4 → `clp_enable` continuous 32 cycles from cycle 3, `done` cycle 39.
- K=4 (or W=3 with K=5) → `done`=`instr_err`=1 at cycle 2, `clp_enable` never high, fields still latched.
- `abort` at cycle 100 of the K=5 run → IDLE at 101, outputs 0, no `done`; a fresh `start` at 102 runs normally.
- `start` pulsed mid-RUN with a different instruction → ignored, latched fields unchanged, original `done` timing kept; `rst_n` low mid-RUN → all outputs 0 immediately.
